// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier
// Sequential unsigned shift-and-add multiplier. One BITS-wide ripple-carry
// adder is reused over BITS iterations to build a 2*BITS-bit product.
// Handshake: start_in is accepted only while ready_out is high; done_out
// pulses for one cycle when product_out has been updated.
// Optional feature macro: MULTIPLIER_ABORT_EN adds abort_in, which returns
// the engine to IDLE from RUN or DONE and blocks acceptance in IDLE.

module shift_add_multiplier #(
    parameter int BITS = 16
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                start_in,
`ifdef MULTIPLIER_ABORT_EN
    input  logic                abort_in,
`endif
    input  logic [BITS-1:0]     a_in,
    input  logic [BITS-1:0]     b_in,
    output logic                ready_out,
    output logic                done_out,
    output logic [2*BITS-1:0]   product_out
);

    localparam int CNT_W = $clog2(BITS + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Explicit ripple-carry chain; returns {carry_out, sum}.
    function automatic logic [BITS:0] ripple_add(input logic [BITS-1:0] x,
                                                 input logic [BITS-1:0] y);
        logic [BITS-1:0] s;
        logic            c;
        c = 1'b0;
        for (int i = 0; i < BITS; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
        end
        return {c, s};
    endfunction

    logic [1:0]          state;
    logic [BITS-1:0]     m;
    logic [BITS-1:0]     acc;
    logic [BITS-1:0]     q;
    logic [CNT_W-1:0]    cnt;

    logic                abort;
    logic [BITS-1:0]     addend;
    logic [BITS:0]       sum_c;
    logic [2*BITS-1:0]   shifted;

`ifdef MULTIPLIER_ABORT_EN
    assign abort = abort_in;
`else
    assign abort = 1'b0;
`endif

    // The single shared adder: ACC plus (Q[0] ? M : 0), carry-in zero.
    assign addend  = q[0] ? m : '0;
    assign sum_c   = ripple_add(acc, addend);

    // Carry-out is kept as the new MSB while the pair shifts right by one.
    assign shifted = {sum_c, q[BITS-1:1]};

    // Handshake outputs are pure decodes of the state register.
    assign ready_out = (state == IDLE);
    assign done_out  = (state == DONE);

    // Control and datapath registers; reset discards any multiply in flight.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= IDLE;
            m           <= '0;
            acc         <= '0;
            q           <= '0;
            cnt         <= '0;
            product_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Abort has priority over a simultaneous start.
                    if (start_in && !abort) begin
                        m     <= a_in;
                        q     <= b_in;
                        acc   <= '0;
                        cnt   <= CNT_W'(BITS);
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        // product_out keeps the last completed result.
                        state <= IDLE;
                    end else begin
                        {acc, q} <= shifted;
                        cnt      <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            product_out <= shifted;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    // One-cycle completion pulse; start_in is ignored here.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Sequential unsigned shift-and-add multiplier for the Mano machine datapath. It time-shares one `BITS`-wide ripple-carry adder across `BITS` iterations to form a `2*BITS`-bit product, trading latency for area. A start/ready/done handshake lets the control unit issue one multiply and wait for completion.

## Interface
Parameters:
- `BITS`, 16, operand width; ≥ 2.

Ports:
- `clk_in`  input  1  clock; all state changes on the rising edge.
- `rst_n_in`  input  1  reset, asynchronous, active-low.
- `start_in`  input  1  request a multiply; sampled only when `ready_out` = 1.
- `a_in`  input  BITS  multiplicand; captured on the accepting edge.
- `b_in`  input  BITS  multiplier; captured on the accepting edge.
- `ready_out`  output  1  high in IDLE only.
- `done_out`  output  1  one-cycle pulse; `product_out` is valid.
- `product_out`  output  2*BITS  last completed product; holds until the next completion.
- `abort_in`  input  1  present only with `MULTIPLIER_ABORT_EN`.

## Operation
- Registers:
  - M (BITS): multiplicand.
  - ACC (BITS): high half.
  - Q (BITS): multiplier, becoming the low half.
  - CNT (ceil(log2(BITS+1))).
  - state: IDLE, RUN, DONE.
- Single adder instance: operands ACC and (Q[0] ? M : 0), carry-in 0, producing sum S and carry-out C.
- IDLE:
  - `start_in` = 1 loads M←`a_in`, Q←`b_in`, ACC←0, CNT←BITS, then enters RUN.
  - `start_in` = 0 stays in IDLE.
- RUN, each edge:
  - {ACC,Q} ← {C,S,Q[BITS-1:1]}, a right shift of the (BITS+1)-bit sum into ACC/Q.
  - CNT ← CNT−1.
  - When CNT = 1 on that edge, enter DONE and load `product_out` ← {C,S,Q[BITS-1:1]}.
- DONE: `done_out` = 1 for exactly one cycle, then unconditionally IDLE. `start_in` is ignored in DONE.
- `start_in` outside IDLE is ignored; it is neither queued nor an error.
- Operand changes after the accepting edge have no effect.
- Arithmetic is unsigned. The product never overflows 2*BITS bits. Carry-out is retained through the shift, never dropped.
- Reset values:
  - state = IDLE, so `ready_out` = 1.
  - `done_out` = 0.
  - `product_out` = 0.
  - M, ACC, Q, CNT = 0.
- Reset mid-operation: the multiply is discarded immediately (asynchronous), all outputs take their reset values, and no `done_out` is produced.

## Timing
- Accepting edge E0: `start_in` and `ready_out` are both 1. `ready_out` falls after E0.
- Iterations occur on edges E1…E_BITS.
- After E_BITS: `done_out` = 1 and `product_out` = new value.
- After E_(BITS+1): `done_out` = 0 and `ready_out` = 1.
- The earliest next accept is E_(BITS+2). Throughput is one product per BITS+2 cycles, and latency is fixed regardless of operand values.
- `done_out` and `ready_out` are never high in the same cycle.
- All outputs are registered or decoded only from the state register. There is no combinational path from inputs to outputs.

## Configuration
- `MULTIPLIER_ABORT_EN` defined: adds port `abort_in` (input, 1).
  - `abort_in` = 1 at an edge in RUN or DONE forces IDLE on that edge.
  - If the abort edge is in RUN, `done_out` is not asserted for the aborted operation.
  - If the abort edge is in DONE, the pulse already shown stands and the result remains visible on `product_out`.
  - `product_out` retains its previous value when an operation is aborted in RUN.
  - In IDLE, `abort_in` = 1 blocks acceptance: abort wins over a simultaneous `start_in`.
- Not defined: no `abort_in` port. Every accepted multiply runs to completion.

## Test plan
- Reset: hold `rst_n_in` = 0 → `ready_out` = 1, `done_out` = 0, `product_out` = 0. Release, idle 3 cycles → outputs unchanged.
- BITS=16, a=3, b=5, start → `done_out` pulses exactly 16 edges after E0, `product_out` = 0x0000000F, `ready_out` returns one cycle later.
- a=0xFFFF, b=0xFFFF → `product_out` = 0xFFFE0001 (exercises carry-out into the shift). a=0x1234, b=0 → `product_out` = 0.
- Pulse `start_in` and change `a_in`/`b_in` during RUN with a=7, b=9 → exactly one `done_out`, `product_out` = 63, and the extra starts are ignored.
- Assert `rst_n_in` = 0 asynchronously at iteration 8 → outputs reset immediately. A new multiply a=2, b=21 then yields 42.
- With `MULTIPLIER_ABORT_EN`:
  - Abort in RUN → no `done_out` and `product_out` keeps its prior value (42).
  - `start_in` and `abort_in` high together in IDLE → not accepted, `ready_out` stays 1.
